// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, base opcodes and the fetch FSM state type.
// Latency: none, declarations only.
// Backpressure: not applicable.
package riscv_pkg;

   // addi x0,x0,0: the canonical bubble seen by the decoder
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Major opcodes, bits [6:0] of the instruction word
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      KILL  = 2'd2,
      HELD  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to a NOP bubble, load a fetched instruction, or hold.
// Latency: one cycle from load/flush to outputs.
// Backpressure: neither load nor flush asserted means hold (stall).
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            load,
   input  logic [31:0]     loadInstr,
   input  logic [XLEN-1:0] loadPc,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   // Flush beats load; a bubble keeps the previous pc so the decoder sees a stable value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         instr <= loadInstr;
         pc    <= loadPc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: pc, imem valid/ready requests, IF/ID register (FETCH_PERF_EN adds perf counters).
// Latency: word accepted in cycle N is on IF/ID in N+1; first request one cycle after reset release.
// Backpressure: imemReady low inserts bubbles; stall parks one word in a hold buffer; branchTaken flushes.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemReady,
   input  logic [31:0]     imemData,
   input  logic            stall,
   input  logic            branchTaken,
   input  logic [XLEN-1:0] branchTarget,
   output logic            ifIdValid,
   output logic [31:0]     ifIdInstruction,
   output logic [XLEN-1:0] ifIdPc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perfFetched,
   output logic [31:0]     perfKilled
`endif
);

   localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

   fetch_state_t    state, stateNext;
   logic [XLEN-1:0] pc, pcNext;
   // Address on the bus; differs from pc only in KILL, where the stale request must finish first
   logic [XLEN-1:0] reqAddr, reqAddrNext;
   logic [31:0]     holdData, holdDataNext;
   logic [XLEN-1:0] holdPc, holdPcNext;
   logic [XLEN-1:0] target;
   logic            handshake;
   logic            ifLoad, ifFlush;
   logic [31:0]     ifLoadInstr;
   logic [XLEN-1:0] ifLoadPc;

   assign target    = branchTarget & WORD_MASK;
   assign imemReq   = (state == FETCH) || (state == KILL);
   assign imemAddr  = reqAddr;
   assign handshake = imemReq && imemReady;

   // Next-state, pc/address update and IF/ID control; branchTaken overrides stall everywhere
   always_comb begin
      stateNext    = state;
      pcNext       = pc;
      reqAddrNext  = reqAddr;
      holdDataNext = holdData;
      holdPcNext   = holdPc;
      ifLoad       = 1'b0;
      ifFlush      = 1'b0;
      ifLoadInstr  = imemData;
      ifLoadPc     = pc;

      if (branchTaken) begin
         ifFlush = 1'b1;
         pcNext  = target;
         if (state == FETCH || state == KILL) begin
            // A request is on the bus: its data is discarded, then the target is fetched
            if (handshake) begin
               reqAddrNext = target;
               stateNext   = FETCH;
            end else begin
               stateNext = KILL;
            end
         end else begin
            // BOOT or HELD: nothing outstanding, the hold buffer is simply abandoned
            reqAddrNext = target;
            stateNext   = FETCH;
         end
      end else begin
         unique case (state)
            BOOT: begin
               ifFlush   = !stall;
               stateNext = FETCH;
            end
            FETCH: begin
               if (handshake) begin
                  pcNext      = pc + PC_STEP;
                  reqAddrNext = pc + PC_STEP;
                  if (stall) begin
                     holdDataNext = imemData;
                     holdPcNext   = pc;
                     stateNext    = HELD;
                  end else begin
                     ifLoad = 1'b1;
                  end
               end else begin
                  ifFlush = !stall;
               end
            end
            HELD: begin
               if (!stall) begin
                  ifLoad      = 1'b1;
                  ifLoadInstr = holdData;
                  ifLoadPc    = holdPc;
                  stateNext   = FETCH;
               end
            end
            KILL: begin
               ifFlush = !stall;
               if (handshake) begin
                  reqAddrNext = pc;
                  stateNext   = FETCH;
               end
            end
            default: stateNext = BOOT;
         endcase
      end
   end

   // State, pc, bus address and hold buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         reqAddr  <= RESET_PC;
         holdData <= NOP_INSTR;
         holdPc   <= '0;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         reqAddr  <= reqAddrNext;
         holdData <= holdDataNext;
         holdPc   <= holdPcNext;
      end
   end

   if_id_reg #(.XLEN(XLEN)) uIfId (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (ifFlush),
      .load      (ifLoad),
      .loadInstr (ifLoadInstr),
      .loadPc    (ifLoadPc),
      .valid     (ifIdValid),
      .instr     (ifIdInstruction),
      .pc        (ifIdPc)
   );

`ifdef FETCH_PERF_EN
   logic discard;

   // A completed handshake is thrown away when it is stale (KILL) or overtaken by a redirect
   assign discard = handshake && (branchTaken || state == KILL);

   // Wrapping event counters: valid writes into IF/ID and discarded memory words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perfFetched <= '0;
         perfKilled  <= '0;
      end else begin
         if (ifLoad && !ifFlush) perfFetched <= perfFetched + 32'd1;
         if (discard)            perfKilled  <= perfKilled + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/ready/branch traffic.
// Latency: checks every cycle, #1 after the rising edge.
// Backpressure: memory model answers every accepted request with an address-derived word.
`timescale 1ns/1ps
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady = 1'b0;
   logic [31:0] imemData;
   logic        stall = 1'b0;
   logic        branchTaken = 1'b0;
   logic [31:0] branchTarget = 32'h0;
   logic        ifIdValid;
   logic [31:0] ifIdInstruction;
   logic [31:0] ifIdPc;
`ifdef FETCH_PERF_EN
   logic [31:0] perfFetched;
   logic [31:0] perfKilled;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[17:2], a[31:18], 2'b11};
   endfunction

   assign imemData = memWord(imemAddr);

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imemReq         (imemReq),
      .imemAddr        (imemAddr),
      .imemReady       (imemReady),
      .imemData        (imemData),
      .stall           (stall),
      .branchTaken     (branchTaken),
      .branchTarget    (branchTarget),
      .ifIdValid       (ifIdValid),
      .ifIdInstruction (ifIdInstruction),
      .ifIdPc          (ifIdPc)
`ifdef FETCH_PERF_EN
      ,
      .perfFetched     (perfFetched),
      .perfKilled      (perfKilled)
`endif
   );

   // Reference model: what the fetch stage is doing, what it has on the bus, what the decoder sees
   typedef enum {M_BOOT, M_FETCH, M_STALE, M_PARKED} mmode_t;
   mmode_t      mMode;
   logic [31:0] mPc, mAddr, mBufW, mBufPc;
   logic        mV;
   logic [31:0] mI, mIPc;
   int unsigned mFet, mKil;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mMode = M_BOOT; mPc = 32'h0; mAddr = 32'h0;
      mV = 1'b0; mI = 32'h0000_0013; mIPc = 32'h0;
      mBufW = 32'h0; mBufPc = 32'h0; mFet = 0; mKil = 0;
   endtask

   task automatic bubble();
      mV = 1'b0;
      mI = 32'h0000_0013;
   endtask

   // One clock of behaviour from the current inputs
   task automatic modelStep();
      logic        busy;
      logic        took;
      logic [31:0] word;
      logic [31:0] tgt;
      busy = (mMode == M_FETCH) || (mMode == M_STALE);
      took = busy && imemReady;
      word = memWord(mAddr);
      tgt  = {branchTarget[31:2], 2'b00};
      if (branchTaken) begin
         bubble();
         mPc = tgt;
         if (took) mKil++;
         if (busy && !took) begin
            mMode = M_STALE;
         end else begin
            mAddr = tgt;
            mMode = M_FETCH;
         end
      end else if (mMode == M_BOOT) begin
         if (!stall) bubble();
         mMode = M_FETCH;
      end else if (mMode == M_PARKED) begin
         if (!stall) begin
            mV = 1'b1; mI = mBufW; mIPc = mBufPc; mFet++;
            mMode = M_FETCH;
         end
      end else if (mMode == M_STALE) begin
         if (took) begin
            mKil++;
            mAddr = mPc;
            mMode = M_FETCH;
         end
         if (!stall) bubble();
      end else begin
         if (took) begin
            if (stall) begin
               mBufW = word; mBufPc = mPc;
               mMode = M_PARKED;
            end else begin
               mV = 1'b1; mI = word; mIPc = mPc; mFet++;
            end
            mPc   = mPc + 32'd4;
            mAddr = mPc;
         end else if (!stall) begin
            bubble();
         end
      end
   endtask

   task automatic compareAll(input string tag);
      chk({tag, ".req"},   32'(imemReq), 32'((mMode == M_FETCH) || (mMode == M_STALE)));
      chk({tag, ".addr"},  imemAddr, mAddr);
      chk({tag, ".valid"}, 32'(ifIdValid), 32'(mV));
      chk({tag, ".instr"}, ifIdInstruction, mI);
      chk({tag, ".pc"},    ifIdPc, mIPc);
`ifdef FETCH_PERF_EN
      chk({tag, ".fetched"}, perfFetched, mFet);
      chk({tag, ".killed"},  perfKilled, mKil);
`endif
   endtask

   task automatic chkResetValues(input string tag);
      chk({tag, ".req"},   32'(imemReq), 32'h0);
      chk({tag, ".addr"},  imemAddr, 32'h0);
      chk({tag, ".valid"}, 32'(ifIdValid), 32'h0);
      chk({tag, ".instr"}, ifIdInstruction, 32'h0000_0013);
      chk({tag, ".pc"},    ifIdPc, 32'h0);
`ifdef FETCH_PERF_EN
      chk({tag, ".fetched"}, perfFetched, 32'h0);
      chk({tag, ".killed"},  perfKilled, 32'h0);
`endif
   endtask

   task automatic drive(input logic s, input logic r, input logic b, input logic [31:0] t);
      stall = s; imemReady = r; branchTaken = b; branchTarget = t;
   endtask

   task automatic tick(input string tag);
      modelStep();
      @(posedge clk);
      #1;
      compareAll(tag);
   endtask

   initial begin
      logic [31:0] savedAddr;
      int unsigned killedBefore;

      // Reset values
      modelReset();
      #12;
      chkResetValues("reset");

      // Back-to-back stream with imemReady high
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("boot");
      chk("boot.firstReq", 32'(imemReq), 32'h1);
      for (int i = 0; i < 10; i++) tick("stream");
      chk("stream.valid", 32'(ifIdValid), 32'h1);

      // Memory not ready for three cycles
      savedAddr = imemAddr;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) tick("noready");
      chk("noready.addrStable", imemAddr, savedAddr);
      chk("noready.bubble", ifIdInstruction, 32'h0000_0013);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("resume");
      chk("resume.pc", ifIdPc, savedAddr);

      // Stall during a handshake, held two cycles
      savedAddr = imemAddr;
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick("stall1");
      chk("stall1.reqLow", 32'(imemReq), 32'h0);
      tick("stall2");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("unstall");
      chk("unstall.pc", ifIdPc, savedAddr);
      chk("unstall.instr", ifIdInstruction, memWord(savedAddr));
      tick("afterStall");
      chk("afterStall.pc", ifIdPc, savedAddr + 32'd4);

      // Redirect while a request waits: stale word must be discarded
      killedBefore = mKil;
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0103);
      tick("kill.br");
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick("kill.wait");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("kill.drop");
      chk("kill.addr", imemAddr, 32'h0000_0100);
      chk("kill.req", 32'(imemReq), 32'h1);
      chk("kill.count", mKil - killedBefore, 32'd1);

      // Redirect together with stall while a word is parked
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick("held.enter");
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0200);
      tick("held.br");
      chk("held.addr", imemAddr, 32'h0000_0200);
      chk("held.valid", 32'(ifIdValid), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("held.target");
      chk("held.targetPc", ifIdPc, 32'h0000_0200);

      // Address wrap at the top of memory
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      tick("wrap.br");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick("wrap.fetch");
      chk("wrap.pc", ifIdPc, 32'hFFFF_FFFC);
      chk("wrap.addr", imemAddr, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic b;
         logic r;
         b = ($urandom_range(9) == 0);
         r = ($urandom_range(3) != 0);
         if (b && mMode == M_STALE) r = 1'b0;
         drive($urandom_range(3) == 0, r, b, $urandom);
         tick("rand");
      end

      // Reset in the middle of a pending request
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick("pend");
      #2;
      rst_n = 1'b0;
      #1;
      chkResetValues("asyncReset");
      modelReset();
      #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) tick("postReset");
      for (int i = 0; i < 100; i++) begin
         drive($urandom_range(3) == 0, $urandom_range(3) != 0, 1'b0, 32'h0);
         tick("rand2");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipeline, directly upstream of the opcode decoder/control unit. Holds the program counter, issues word requests to instruction memory over a valid/ready handshake, and presents one instruction per cycle through the IF/ID pipeline register. Handles stall back-pressure from hazard logic and branch redirects from the execute stage, injecting NOP bubbles (`addi x0,x0,0` = 0x00000013) whenever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `XLEN`, 32, address/data width; only 32 supported.
- `clk` input 1 — single clock; all state updates on its rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `imemReq` output 1 — fetch request valid.
- `imemAddr` output XLEN — word address of request, bits [1:0] always 0.
- `imemReady` input 1 — memory accepts request and returns data this cycle.
- `imemData` input 32 — instruction word; valid when `imemReq && imemReady`.
- `stall` input 1 — hazard unit: hold IF/ID contents.
- `branchTaken` input 1 — redirect fetch to `branchTarget`, flush IF/ID.
- `branchTarget` input XLEN — redirect address; bits [1:0] forced to 0.
- `ifIdValid` output 1 — IF/ID holds a real instruction.
- `ifIdInstruction` output 32 — instruction to decoder (opcode = bits [6:0]).
- `ifIdPc` output XLEN — PC of `ifIdInstruction`.

## Operation
- A handshake completes in a cycle where `imemReq && imemReady`. `imemAddr` stays stable while `imemReq` is high until completion.
- States: BOOT, FETCH, KILL, HELD.
- BOOT: entered on reset; `imemReq`=0; always goes to FETCH next cycle.
- FETCH: `imemReq`=1, `imemAddr`=pc.
  - `branchTaken`: pc←target. On handshake this cycle, discard data and stay FETCH. Without handshake, go KILL.
  - Handshake, no stall: IF/ID←{1, imemData, pc}; pc←pc+4.
  - Handshake with stall: data→one-entry hold buffer; pc←pc+4; go HELD.
  - No handshake, no stall: IF/ID←bubble (valid 0, NOP, pc unchanged).
- HELD: `imemReq`=0. When `stall` drops, IF/ID←buffer; go FETCH.
- KILL: `imemReq`=1 on the stale address. On handshake, discard data and go FETCH (pc already redirected).
- Any state, `stall`=1 and no branch: IF/ID holds its value.
- `branchTaken` overrides `stall`:
  - IF/ID←bubble.
  - Hold buffer cleared.
  - HELD→FETCH.
  - In KILL, pc updates to the newest target; state stays KILL.
- pc+4 wraps modulo 2^32.
- Reset asserted mid-transaction: all state clears immediately. The outstanding request is abandoned; memory must tolerate `imemReq` dropping.

## Timing
- Reset values:
  - `imemReq`=0, `imemAddr`=RESET_PC.
  - `ifIdValid`=0, `ifIdInstruction`=32'h0000_0013, `ifIdPc`=0.
  - State BOOT.
- First request is issued in the first cycle after `rst_n` rises plus one (BOOT cycle).
- Fetch-to-decode latency: data accepted in cycle N appears on IF/ID outputs in cycle N+1.
- Throughput: one instruction per cycle with `imemReady` held high.
- Branch penalty: redirect in cycle N → target request in N+1 (FETCH), or after the stale handshake completes (KILL).
- All outputs are registered. `imemAddr` is not combinationally dependent on `branchTarget`.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perfFetched` (32-bit) and `perfKilled` (32-bit), both reset to 0 and wrapping.
  - `perfFetched` increments per instruction written valid into IF/ID.
  - `perfKilled` increments per handshake whose data is discarded.
- `FETCH_PERF_EN` undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INSTR` (32'h0000_0013).
  - Opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP_IMM 0010011, OP 0110011), shared with the decoder.
  - The `fetch_state_t` enum.
- Sub-module `if_id_reg`: the IF/ID register with hold/flush/load controls and reset-to-NOP. All remaining logic stays in `fetch_unit`.

## Test plan
- Reset release, `imemReady`=1, memory returns addr-derived words → IF/ID shows pc 0,4,8… back-to-back from cycle 3; `ifIdValid` continuous.
- `imemReady` low 3 cycles mid-stream → three bubbles (valid 0, 0x00000013), `imemAddr` stable, then resumes at the same pc.
- `stall` high 2 cycles during a handshake → IF/ID held, `imemReq` low in HELD, buffered word appears the cycle after `stall` falls, no instruction lost or duplicated.
- `branchTaken` with target 0x0000_0103 while request pending and `imemReady` low → KILL. Stale word discarded on ready; next request at 0x0000_0100; `perfKilled`=1 if enabled.
- `branchTaken` and `stall` together in HELD → IF/ID bubble, buffer dropped, next request at target.
- pc at 0xFFFF_FFFC fetched → next `imemAddr` 0x0000_0000; `rst_n` pulsed mid-request → outputs at reset values asynchronously.
